// File: rtl/fp_to_dec_seq_if.sv
// -----------------------------------------------------------------------------
// fp_to_dec_seq_if
// Request/result bundle for fp_to_dec_seq.
//   start    : request conversion of fp_in (taken only while ready=1)
//   fp_in    : IEEE-754 single-precision operand
//   ready    : converter idle
//   valid    : one-cycle pulse, result fields updated
//   sign     : result sign
//   int_dig  : BCD integer digit
//   frac_dig : NDIG BCD fraction digits, first digit in the MSBs
//   dexp     : signed decimal exponent
//   zero     : operand was +/-0 or denormal
//   special  : operand was Inf/NaN
// master drives start/fp_in; slave (the converter) drives the rest.
// -----------------------------------------------------------------------------
interface fp_to_dec_seq_if #(
    parameter int NDIG = 5
);
    logic                start;
    logic [31:0]         fp_in;
    logic                ready;
    logic                valid;
    logic                sign;
    logic [3:0]          int_dig;
    logic [4*NDIG-1:0]   frac_dig;
    logic [8:0]          dexp;
    logic                zero;
    logic                special;

    modport master (
        output start, fp_in,
        input  ready, valid, sign, int_dig, frac_dig, dexp, zero, special
    );

    modport slave (
        input  start, fp_in,
        output ready, valid, sign, int_dig, frac_dig, dexp, zero, special
    );
endinterface

// File: rtl/fp_to_dec_seq.sv
// -----------------------------------------------------------------------------
// fp_to_dec_seq
// Sequential IEEE-754 single -> decimal scientific converter
// (sign, int digit, NDIG fraction digits, decimal exponent) built around a
// single shift/add mantissa datapath and a W-cycle restoring divide-by-10.
// Ports:
//   CLK3 : clock, rising edge
//   RST  : asynchronous active-low reset
//   bus  : fp_to_dec_seq_if.slave (start/fp_in in, results out)
// Optional build macro: FP_TO_DEC_ROUND_EN
//   defined   -> extra guard digit and a ROUND state (round half up)
//   undefined -> truncated result
//
// state  | meaning
// IDLE   | ready, waiting for start
// LOAD   | classify operand, unpack mantissa/exponent
// BIN    | remove binary exponent by shifts and x10 steps
// DIV    | restoring M = floor(M/10), D++, back to caller
// NORM   | bring M into [1,10), extract integer digit
// DIGIT  | x10 per cycle, peel fraction digits
// ROUND  | add guard-digit carry (ROUND_EN builds only)
// DONE   | publish results, valid next cycle
// -----------------------------------------------------------------------------
module fp_to_dec_seq #(
    parameter int NDIG = 5,
    parameter int W    = 40,
    parameter int FB   = 32
) (
    input  logic           CLK3,
    input  logic           RST,
    fp_to_dec_seq_if.slave bus
);
    localparam int FW  = 4*NDIG;
    localparam int BCW = $clog2(W+1);
    localparam logic [W-1:0] ONE   = W'(1) << FB;
    localparam logic [W-1:0] EIGHT = W'(8) << FB;
    localparam logic [W-1:0] TEN   = W'(10) << FB;
    localparam logic [W-1:0] TOP   = W'(1) << (W-1);
    localparam logic [W-1:0] FMASK = ONE - W'(1);
`ifdef FP_TO_DEC_ROUND_EN
    localparam logic [3:0] DIG_LAST = 4'(NDIG);
`else
    localparam logic [3:0] DIG_LAST = 4'(NDIG-1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_BIN, S_DIV, S_NORM, S_DIGIT, S_ROUND, S_DONE
    } state_t;

    state_t            state_q, state_d, ret_q, ret_d;
    logic [31:0]       fp_q, fp_d;
    logic [W-1:0]      m_q, m_d, m10;
    logic signed [8:0] e_q, e_d, d_q, d_d;
    logic [3:0]        rem_q, rem_d;
    logic [4:0]        r2;
    logic              q_bit;
    logic [BCW-1:0]    bit_q, bit_d;
    logic [3:0]        dig_q, dig_d, int_q, int_d;
    logic [FW-1:0]     frac_q, frac_d;
    logic              zero_q, zero_d, special_q, special_d;
    logic              o_valid_q, o_valid_d, o_sign_q, o_sign_d;
    logic              o_zero_q, o_zero_d, o_special_q, o_special_d;
    logic [3:0]        o_int_q, o_int_d;
    logic [FW-1:0]     o_frac_q, o_frac_d;
    logic [8:0]        o_dexp_q, o_dexp_d;
`ifdef FP_TO_DEC_ROUND_EN
    logic [3:0]        guard_q, guard_d, rd;
    logic              cy;
`endif

    // state register
    always_ff @(posedge CLK3 or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_LOAD;
            S_LOAD:  state_d = (fp_q[30:23] == 8'h00 || fp_q[30:23] == 8'hFF) ? S_DONE : S_BIN;
            S_BIN: begin
                if (e_q == 9'sd0)                 state_d = S_NORM;
                else if (e_q > 0 && m_q >= TOP)   state_d = S_DIV;
            end
            S_DIV:   if (bit_q == '0) state_d = ret_q;
            S_NORM: begin
                if (m_q >= TEN)       state_d = S_DIV;
                else if (m_q >= ONE)  state_d = S_DIGIT;
            end
`ifdef FP_TO_DEC_ROUND_EN
            S_DIGIT: if (dig_q == '0) state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
`else
            S_DIGIT: if (dig_q == '0) state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // datapath next values
    always_comb begin
        fp_d = fp_q;  m_d = m_q;  e_d = e_q;  d_d = d_q;  ret_d = ret_q;
        rem_d = rem_q;  bit_d = bit_q;  dig_d = dig_q;
        int_d = int_q;  frac_d = frac_q;  zero_d = zero_q;  special_d = special_q;
        o_valid_d = 1'b0;  o_sign_d = o_sign_q;  o_int_d = o_int_q;
        o_frac_d = o_frac_q;  o_dexp_d = o_dexp_q;
        o_zero_d = o_zero_q;  o_special_d = o_special_q;
        m10   = (m_q << 3) + (m_q << 1);
        r2    = {rem_q, m_q[W-1]};
        q_bit = (r2 >= 5'd10);
`ifdef FP_TO_DEC_ROUND_EN
        guard_d = guard_q;  rd = 4'd0;  cy = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (bus.start) begin
                fp_d = bus.fp_in;  m_d = '0;  e_d = '0;  d_d = '0;
                int_d = '0;  frac_d = '0;  zero_d = 1'b0;  special_d = 1'b0;
            end
            S_LOAD: begin
                if (fp_q[30:23] == 8'h00)      zero_d    = 1'b1;
                else if (fp_q[30:23] == 8'hFF) special_d = 1'b1;
                else begin
                    m_d = W'({1'b1, fp_q[22:0]}) << (FB-23);
                    e_d = $signed({1'b0, fp_q[30:23]}) - 9'sd127;
                    d_d = '0;
                end
            end
            S_BIN: if (e_q > 0) begin
                if (m_q < TOP) begin
                    m_d = m_q << 1;  e_d = e_q - 9'sd1;
                end else begin
                    rem_d = '0;  bit_d = BCW'(W-1);  ret_d = S_BIN;
                end
            end else if (e_q < 0) begin
                // below 8 a x10 step cannot overflow; otherwise halve (lossy)
                if (m_q < EIGHT) begin
                    m_d = m10;  d_d = d_q - 9'sd1;
                end else begin
                    m_d = m_q >> 1;  e_d = e_q + 9'sd1;
                end
            end
            S_DIV: begin
                // quotient bits shift into M as the dividend shifts out
                rem_d = q_bit ? 4'(r2 - 5'd10) : r2[3:0];
                m_d   = {m_q[W-2:0], q_bit};
                bit_d = bit_q - BCW'(1);
                if (bit_q == '0) d_d = d_q + 9'sd1;
            end
            S_NORM: begin
                if (m_q >= TEN) begin
                    rem_d = '0;  bit_d = BCW'(W-1);  ret_d = S_NORM;
                end else if (m_q < ONE) begin
                    m_d = m10;  d_d = d_q - 9'sd1;
                end else begin
                    int_d = m_q[FB+3:FB];  m_d = m_q & FMASK;  dig_d = DIG_LAST;
                end
            end
            S_DIGIT: begin
                m_d   = m10 & FMASK;
                dig_d = dig_q - 4'd1;
`ifdef FP_TO_DEC_ROUND_EN
                if (dig_q == '0) guard_d = m10[FB+3:FB];
                else             frac_d  = FW'({frac_q, m10[FB+3:FB]});
`else
                frac_d = FW'({frac_q, m10[FB+3:FB]});
`endif
            end
`ifdef FP_TO_DEC_ROUND_EN
            S_ROUND: begin
                cy = (guard_q >= 4'd5);
                for (int i = 0; i < NDIG; i++) begin
                    rd = frac_q[4*i +: 4] + {3'b000, cy};
                    cy = (rd == 4'd10);
                    frac_d[4*i +: 4] = cy ? 4'd0 : rd;
                end
                // 9.99..9 rolling over renormalises to 1.00..0 x10
                if (cy) begin
                    if (int_q == 4'd9) begin
                        int_d = 4'd1;  d_d = d_q + 9'sd1;
                    end else begin
                        int_d = int_q + 4'd1;
                    end
                end
            end
`endif
            S_DONE: begin
                o_valid_d = 1'b1;  o_sign_d = fp_q[31];  o_int_d = int_q;
                o_frac_d = frac_q;  o_dexp_d = d_q;
                o_zero_d = zero_q;  o_special_d = special_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK3 or negedge RST) begin
        if (!RST) begin
            fp_q <= '0;  m_q <= '0;  e_q <= '0;  d_q <= '0;  ret_q <= S_IDLE;
            rem_q <= '0;  bit_q <= '0;  dig_q <= '0;  int_q <= '0;  frac_q <= '0;
            zero_q <= 1'b0;  special_q <= 1'b0;
            o_valid_q <= 1'b0;  o_sign_q <= 1'b0;  o_int_q <= '0;  o_frac_q <= '0;
            o_dexp_q <= '0;  o_zero_q <= 1'b0;  o_special_q <= 1'b0;
`ifdef FP_TO_DEC_ROUND_EN
            guard_q <= '0;
`endif
        end else begin
            fp_q <= fp_d;  m_q <= m_d;  e_q <= e_d;  d_q <= d_d;  ret_q <= ret_d;
            rem_q <= rem_d;  bit_q <= bit_d;  dig_q <= dig_d;  int_q <= int_d;  frac_q <= frac_d;
            zero_q <= zero_d;  special_q <= special_d;
            o_valid_q <= o_valid_d;  o_sign_q <= o_sign_d;  o_int_q <= o_int_d;  o_frac_q <= o_frac_d;
            o_dexp_q <= o_dexp_d;  o_zero_q <= o_zero_d;  o_special_q <= o_special_d;
`ifdef FP_TO_DEC_ROUND_EN
            guard_q <= guard_d;
`endif
        end
    end

    // outputs
    always_comb begin
        bus.ready    = (state_q == S_IDLE);
        bus.valid    = o_valid_q;
        bus.sign     = o_sign_q;
        bus.int_dig  = o_int_q;
        bus.frac_dig = o_frac_q;
        bus.dexp     = o_dexp_q;
        bus.zero     = o_zero_q;
        bus.special  = o_special_q;
    end
endmodule

// File: tb/tb_fp_to_dec_seq.sv
module tb_fp_to_dec_seq;
    localparam int NDIG  = 5;
    localparam int W     = 40;
    localparam int FB    = 32;
    localparam int FW    = 4*NDIG;
    localparam int BOUND = 2 + 128*(W+1) + 2*W + NDIG + 1 + 8;

    typedef struct packed {
        logic          sign;
        logic [3:0]    int_dig;
        logic [FW-1:0] frac_dig;
        logic [8:0]    dexp;
        logic          zero;
        logic          special;
    } res_t;

    typedef struct {
        logic [31:0] fp;
        res_t        exp;
    } vec_t;

    logic CLK3 = 1'b0;
    logic RST  = 1'b0;
    always #5 CLK3 = ~CLK3;

    fp_to_dec_seq_if #(.NDIG(NDIG)) bus();

    fp_to_dec_seq #(.NDIG(NDIG), .W(W), .FB(FB)) dut (
        .CLK3 (CLK3),
        .RST  (RST),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cnt = 0;

    always @(posedge CLK3) if (bus.valid === 1'b1) valid_cnt <= valid_cnt + 1;

    function automatic res_t mk(input logic s, input logic [3:0] i, input logic [FW-1:0] f,
                                input int dx, input logic z, input logic sp);
        res_t r;
        r.sign = s;  r.int_dig = i;  r.frac_dig = f;  r.dexp = 9'(dx);
        r.zero = z;  r.special = sp;
        return r;
    endfunction

    // Value-level reference: follows the conversion rules on plain integers
    // and builds the digits as one decimal number, then splits it into BCD.
    function automatic res_t ref_model(input logic [31:0] fp);
        res_t r;
        longint unsigned m, one, dec, p10;
        int e, d;
        r = '0;
        r.sign = fp[31];
        if (fp[30:23] == 8'h00) begin r.zero = 1'b1; return r; end
        if (fp[30:23] == 8'hFF) begin r.special = 1'b1; return r; end
        one = 64'd1 << FB;
        m = {40'd0, 1'b1, fp[22:0]} << (FB-23);
        e = int'(fp[30:23]) - 127;
        d = 0;
        while (e > 0) begin
            if (m < (64'd1 << (W-1))) begin m = m * 2; e--; end
            else begin m = m / 10; d++; end
        end
        while (e < 0) begin
            if (m < 8*one) begin m = m * 10; d--; end
            else begin m = m / 2; e++; end
        end
        while (m >= 10*one || m < one) begin
            if (m >= 10*one) begin m = m / 10; d++; end
            else begin m = m * 10; d--; end
        end
        dec = m / one;
        m   = m % one;
        p10 = 1;
        for (int k = 0; k < NDIG; k++) begin
            m   = m * 10;
            dec = dec * 10 + m / one;
            m   = m % one;
            p10 = p10 * 10;
        end
`ifdef FP_TO_DEC_ROUND_EN
        m = m * 10;
        if (m / one >= 5) dec = dec + 1;
        if (dec == p10 * 10) begin dec = p10; d++; end
`endif
        r.int_dig = 4'(dec / p10);
        dec = dec % p10;
        for (int k = 0; k < NDIG; k++) begin
            r.frac_dig[4*k +: 4] = 4'(dec % 10);
            dec = dec / 10;
        end
        r.dexp = 9'(d);
        return r;
    endfunction

    function automatic res_t get_out();
        return {bus.sign, bus.int_dig, bus.frac_dig, bus.dexp, bus.zero, bus.special};
    endfunction

    task automatic check_res(input string name, input logic [31:0] fp, input res_t got, input res_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s fp=%08h got s=%0b int=%h frac=%h dexp=%0d z=%0b sp=%0b want s=%0b int=%h frac=%h dexp=%0d z=%0b sp=%0b",
                     name, fp, got.sign, got.int_dig, got.frac_dig, $signed(got.dexp), got.zero, got.special,
                     want.sign, want.int_dig, want.frac_dig, $signed(want.dexp), want.zero, want.special);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic conv_check(input string name, input logic [31:0] fp, input res_t want);
        int n;
        res_t r;
        n = 0;
        while (bus.ready !== 1'b1 && n < BOUND) begin @(negedge CLK3); n++; end
        bus.fp_in = fp;
        bus.start = 1'b1;
        @(negedge CLK3);
        bus.start = 1'b0;
        n = 0;
        while (bus.valid !== 1'b1 && n < BOUND) begin @(negedge CLK3); n++; end
        if (bus.valid !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout fp=%08h got valid=%b want 1 within %0d cycles", name, fp, bus.valid, BOUND);
        end else begin
            r = get_out();
            check_res(name, fp, r, want);
        end
        @(negedge CLK3);
    endtask

    vec_t tbl[11];

    initial begin
        logic [37:0] rst_view;
        logic [31:0] fp;
        res_t        r;
        int          v0, n;

        bus.start = 1'b0;
        bus.fp_in = '0;

        tbl[0]  = '{32'h3F800000, mk(1'b0, 4'd1, 20'h00000,  0, 1'b0, 1'b0)};
        tbl[1]  = '{32'h41200000, mk(1'b0, 4'd1, 20'h00000,  1, 1'b0, 1'b0)};
        tbl[2]  = '{32'hBF000000, mk(1'b1, 4'd5, 20'h00000, -1, 1'b0, 1'b0)};
        tbl[3]  = '{32'h40490FDB, mk(1'b0, 4'd3, 20'h14159,  0, 1'b0, 1'b0)};
        tbl[4]  = '{32'h3DCCCCCD, mk(1'b0, 4'd1, 20'h00000, -1, 1'b0, 1'b0)};
        tbl[5]  = '{32'h80000000, mk(1'b1, 4'd0, 20'h00000,  0, 1'b1, 1'b0)};
        tbl[6]  = '{32'h7F800000, mk(1'b0, 4'd0, 20'h00000,  0, 1'b0, 1'b1)};
        tbl[7]  = '{32'h00000001, mk(1'b0, 4'd0, 20'h00000,  0, 1'b1, 1'b0)};
`ifdef FP_TO_DEC_ROUND_EN
        tbl[8]  = '{32'h3F7FFFFF, mk(1'b0, 4'd1, 20'h00000,  0, 1'b0, 1'b0)};
`else
        tbl[8]  = '{32'h3F7FFFFF, mk(1'b0, 4'd9, 20'h99999, -1, 1'b0, 1'b0)};
`endif
        tbl[9]  = '{32'h7F7FFFFF, mk(1'b0, 4'd3, 20'h40282, 38, 1'b0, 1'b0)};
        tbl[10] = '{32'hFFC00000, mk(1'b1, 4'd0, 20'h00000,  0, 1'b0, 1'b1)};

        // reset state
        repeat (3) @(negedge CLK3);
        rst_view = {bus.ready, bus.valid, get_out()};
        n_tests++;
        if (rst_view !== {1'b1, 1'b0, 36'd0}) begin
            n_fail++;
            $display("FAIL reset_state got=%h want=%h", rst_view, {1'b1, 1'b0, 36'd0});
        end
        RST = 1'b1;
        @(negedge CLK3);

        // directed table
        for (int i = 0; i < 11; i++) conv_check($sformatf("vec%0d", i), tbl[i].fp, tbl[i].exp);

        // random operands against the value-level model
        for (int i = 0; i < 30; i++) begin
            fp = $urandom;
            conv_check($sformatf("rand%0d", i), fp, ref_model(fp));
        end

        // start held high all through a conversion: one result, no queued work
        n = 0;
        while (bus.ready !== 1'b1 && n < BOUND) begin @(negedge CLK3); n++; end
        v0 = valid_cnt;
        bus.fp_in = 32'h41200000;
        bus.start = 1'b1;
        @(negedge CLK3);
        n = 0;
        while (bus.valid !== 1'b1 && n < BOUND) begin
            bus.fp_in = $urandom;
            bus.start = 1'b1;
            @(negedge CLK3);
            n++;
        end
        bus.start = 1'b0;
        r = get_out();
        check_res("busy_start_result", 32'h41200000, r, tbl[1].exp);
        repeat (300) @(negedge CLK3);
        check_int("busy_start_valid_count", valid_cnt - v0, 1);
        check_int("busy_start_ready_after", int'(bus.ready), 1);

        // reset dropped while dividing on FLT_MAX
        v0 = valid_cnt;
        bus.fp_in = 32'h7F7FFFFF;
        bus.start = 1'b1;
        @(negedge CLK3);
        bus.start = 1'b0;
        repeat (15) @(negedge CLK3);
        RST = 1'b0;
        #1;
        rst_view = {bus.ready, bus.valid, get_out()};
        n_tests++;
        if (rst_view !== {1'b1, 1'b0, 36'd0}) begin
            n_fail++;
            $display("FAIL midreset_state got=%h want=%h", rst_view, {1'b1, 1'b0, 36'd0});
        end
        repeat (2) @(negedge CLK3);
        RST = 1'b1;
        repeat (100) @(negedge CLK3);
        check_int("midreset_no_valid", valid_cnt - v0, 0);
        check_int("midreset_ready", int'(bus.ready), 1);
        conv_check("midreset_restart", 32'h7F7FFFFF, tbl[9].exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_to_dec_seq.md
Name: fp_to_dec_seq

Overview:
- Parametrised sequential converter: IEEE-754 single-precision word in, normalised decimal scientific form out.
- Output form: sign, one integer BCD digit, NDIG fraction BCD digits, signed decimal exponent.
- Uses one shift/add datapath with a multi-cycle restoring divide-by-10. No power/mult cores.
- Sits in the FloatToNum path as the generalised successor of the fixed-width positive/negative-exponent ALU pair.

Parameters:
- NDIG, 5, number of fraction BCD digits produced (1..8).
- W, 40, internal mantissa register width in bits.
- FB, 32, fractional bits of the internal mantissa; W-FB >= 7 and FB >= 23 required.

Ports:
- CLK3  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  request conversion of fp_in; accepted only when ready=1.
- fp_in  in  32  IEEE-754 single, sampled on the accepted start.
- ready  out  1  idle, can accept start.
- valid  out  1  one-cycle pulse, results updated.
- sign  out  1  sign of the result.
- int_dig  out  4  BCD integer digit; 1..9, or 0 for zero.
- frac_dig  out  4*NDIG  BCD fraction digits; first digit in the MSBs.
- dexp  out  9  signed two's-complement decimal exponent.
- zero  out  1  input was ±0 or denormal.
- special  out  1  input exp field = 255 (Inf/NaN).

Behaviour:
- Reset (async, any state): FSM to IDLE; ready=1; all other outputs and internal registers 0.
- Reset mid-conversion aborts the conversion with no valid pulse.
- Internal state: M unsigned W bits, value = M/2^FB; E signed 9-bit binary exponent; D signed 9-bit decimal exponent; digit counter; bit counter for DIV.
- IDLE: on start, latch fp_in, ready=0, go to LOAD. start while ready=0 is ignored and not queued.
- LOAD (1 cycle):
  - exp field = 0 (zero/denormal, flushed): zero=1, digits=0, dexp=0, go to DONE.
  - exp field = 255: special=1, digits=0, dexp=0, go to DONE.
  - Otherwise M = {1,frac} << (FB-23), E = exp-127, D = 0, go to BIN.
- BIN (one step per cycle, until E=0, then NORM):
  - E>0 and M < 2^(W-1): M <<= 1, E--.
  - E>0 and M >= 2^(W-1): go to DIV.
  - E<0 and M < 8*2^FB: M = (M<<3)+(M<<1), D--.
  - E<0 and M >= 8*2^FB: M >>= 1 (truncate), E++.
- DIV: restoring division, exactly W cycles; M = floor(M/10), D++; return to the calling state.
- NORM:
  - M >= 10*2^FB: go to DIV.
  - M < 2^FB: M *= 10, D-- (1 cycle).
  - Otherwise int_dig = M[FB+3:FB], M keeps only its FB fractional bits, go to DIGIT.
- DIGIT (NDIG cycles): each cycle M *= 10, next digit = M[FB+3:FB], clear integer bits. Digits fill frac_dig from the MSBs down.
- DONE (1 cycle): register outputs, valid=1, dexp=D, ready=1 next cycle, return to IDLE.
- Outputs hold their values until the next valid or reset.
- sign = fp_in[31] for all inputs, including zero and special.
- A start in the same cycle as DONE is ignored, because ready is still 0.
- Without rounding the result is truncated; a value just below a decimal boundary may show all 9s.
- Latency is data-dependent. Bound: <= 2 + 128*(W+1) + 2*W + NDIG + 1 cycles; the bench timeout uses this bound.

Optional Feature:
- Macro: FP_TO_DEC_ROUND_EN.
- Defined:
  - DIGIT computes one extra guard digit; ROUND state (1 cycle) adds 1 to the last fraction digit when guard >= 5.
  - BCD carry propagates up through int_dig.
  - If int_dig would become 10: int_dig=1, frac_dig=0, D++.
  - Latency +2 cycles.
- Undefined: truncation only; no ROUND state; guard digit not computed.

Test Plan:
- Basic values, one start each: 0x3F800000 -> int_dig=1, frac_dig=00000, dexp=0, sign=0. 0x41200000 -> 1/00000/dexp=1. 0xBF000000 -> sign=1, 5/00000/dexp=-1.
- Fraction digits: 0x40490FDB (pi) -> 3/14159/dexp=0, in both macro builds. 0x3DCCCCCD -> 1/00000/dexp=-1.
- Special inputs: 0x80000000 -> zero=1, sign=1, all digits 0, dexp=0. 0x7F800000 -> special=1. 0x00000001 -> zero=1.
- Rounding (FP_TO_DEC_ROUND_EN): 0x3F7FFFFF (0.99999994) -> 1/00000/dexp=0. Without the macro -> 9/99999/dexp=-1.
- Handshake: start pulsed every cycle while busy -> exactly one valid per accepted start; inputs presented while ready=0 never converted.
- Mid-conversion reset: drop RST during DIV on 0x7F7FFFFF -> outputs 0, ready=1, no valid. Restart with 0x7F7FFFFF -> 3/40282/dexp=38.
